// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; default is a registered 1-cycle read.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wr_accept, rd_accept;
    logic [WIDTH-1:0] head_word;

    assign head_word = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_accept = wr_en && !full_q;
        rd_accept = rd_en && !empty_q;

        wr_ptr_d = wr_accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_accept ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase

        // Status is computed from the post-edge pointers so the flags are pure flops.
        full_d         = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d        = (wr_ptr_d == rd_ptr_d);
        almost_full_d  = (count_d >= AF_L);
        almost_empty_d = (count_d <= AE_L);

        overflow_d = overflow_q;
        if (err_clr)           overflow_d = 1'b0;
        if (wr_en && full_q)   overflow_d = 1'b1;

        underflow_d = underflow_q;
        if (err_clr)           underflow_d = 1'b0;
        if (rd_en && empty_q)  underflow_d = 1'b1;

`ifdef SYNC_FIFO_FWFT_EN
        dout_d = empty_q ? dout_q : head_word;
`else
        dout_d = rd_accept ? head_word : dout_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            dout_q         <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            dout_q         <= dout_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown live; dout_q only remembers the last word for when the FIFO empties.
    assign data_out = empty_q ? dout_q : head_word;
    assign rd_valid = !empty_q;
`else
    logic rd_valid_q, rd_valid_d;

    always_comb begin
        rd_valid_d = rd_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_out = dout_q;
    assign rd_valid = rd_valid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DEPTH=8, AF=6, AE=2).
// Read data is sampled before the edge in the FWFT build and after it in the standard build.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    int unsigned total = 0;
    int unsigned bad = 0;

    sync_fifo_param #(
        .WIDTH(8),
        .DEPTH(8),
        .AF_LEVEL(6),
        .AE_LEVEL(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .data_in(data_in),
        .rd_en(rd_en),
        .data_out(data_out),
        .rd_valid(rd_valid),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; returns the word/valid that a read in this cycle delivers.
    task automatic xfer(input logic wr, input logic [7:0] din, input logic rd, input logic clr,
                        output logic [7:0] word, output logic vld);
        wr_en = wr; data_in = din; rd_en = rd; err_clr = clr;
`ifdef SYNC_FIFO_FWFT_EN
        word = data_out; vld = rd_valid;
        @(posedge clk); #1;
`else
        @(posedge clk); #1;
        word = data_out; vld = rd_valid;
`endif
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] w;
        logic       v;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({count, empty, full, almost_empty, almost_full, data_out, rd_valid, overflow, underflow}
            !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got cnt=%0d e=%b f=%b ae=%b af=%b do=%h v=%b ov=%b un=%b",
                     count, empty, full, almost_empty, almost_full, data_out, rd_valid, overflow, underflow);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) xfer(1'b1, 8'(8'h71 + i), 1'b0, 1'b0, w, v);
        xfer(1'b0, 8'h00, 1'b1, 1'b0, w, v);
        total++;
        if (count !== 4'd5) begin
            bad++; $display("FAIL pre_reset_count got=%0d exp=5", count);
        end
        rst_n = 1'b0;
        #2;
        total++;
        if ({count, empty, full, almost_empty, almost_full, data_out, rd_valid, overflow, underflow}
            !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got cnt=%0d e=%b f=%b ae=%b af=%b do=%h v=%b ov=%b un=%b",
                     count, empty, full, almost_empty, almost_full, data_out, rd_valid, overflow, underflow);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1'b1, 8'hA5, 1'b0, 1'b0, w, v);
        xfer(1'b0, 8'h00, 1'b1, 1'b0, w, v);
        total++;
        if ({w, v, empty} !== {8'hA5, 1'b1, 1'b1}) begin
            bad++; $display("FAIL post_reset_read got word=%h vld=%b empty=%b exp word=a5 vld=1 empty=1", w, v, empty);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] w;
        logic       v;
        for (int i = 0; i < 10; i++) begin
            xfer(1'b1, 8'(i), 1'b0, 1'b0, w, v);
            total++;
            if ({count, full, overflow} !== {4'((i < 8) ? i + 1 : 8), 1'(i >= 7), 1'(i >= 8)}) begin
                bad++;
                $display("FAIL overflow_fill write=%0d got cnt=%0d full=%b ov=%b exp cnt=%0d full=%b ov=%b",
                         i, count, full, overflow, (i < 8) ? i + 1 : 8, i >= 7, i >= 8);
            end
        end
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 8'h00, 1'b1, 1'b0, w, v);
            total++;
            if ({w, v} !== {8'(i), 1'b1}) begin
                bad++; $display("FAIL overflow_readback idx=%0d got word=%h vld=%b exp word=%h vld=1", i, w, v, i);
            end
        end
        total++;
        if (empty !== 1'b1) begin
            bad++; $display("FAIL overflow_drained empty got=%b exp=1", empty);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] w;
        logic       v;
        xfer(1'b0, 8'h00, 1'b0, 1'b1, w, v);
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL overflow_clear got=%b exp=0", overflow);
        end
        for (int i = 0; i < 8; i++) xfer(1'b1, 8'(i), 1'b0, 1'b0, w, v);
        for (int i = 0; i < 10; i++) begin
            xfer(1'b0, 8'h00, 1'b1, 1'b0, w, v);
            total++;
            if ({w, v} !== {(i < 8) ? 8'(i) : 8'h07, 1'(i < 8)}) begin
                bad++; $display("FAIL underflow_read idx=%0d got word=%h vld=%b exp word=%h vld=%b",
                                i, w, v, (i < 8) ? i : 7, i < 8);
            end
        end
        total++;
        if ({empty, count, underflow, overflow} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL underflow_flags got e=%b cnt=%0d un=%b ov=%b exp e=1 cnt=0 un=1 ov=0",
                            empty, count, underflow, overflow);
        end
        xfer(1'b0, 8'h00, 1'b0, 1'b1, w, v);
        total++;
        if (underflow !== 1'b0) begin
            bad++; $display("FAIL underflow_clear got=%b exp=0", underflow);
        end
        xfer(1'b0, 8'h00, 1'b1, 1'b1, w, v);
        total++;
        if (underflow !== 1'b1) begin
            bad++; $display("FAIL clear_vs_new_error got=%b exp=1", underflow);
        end
        xfer(1'b0, 8'h00, 1'b0, 1'b1, w, v);
    endtask

    task automatic test_simultaneous();
        logic [7:0] w;
        logic       v;
        for (int i = 0; i < 4; i++) xfer(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, w, v);
        for (int i = 0; i < 20; i++) begin
            xfer(1'b1, 8'(8'h14 + i), 1'b1, 1'b0, w, v);
            total++;
            if ({w, v, count} !== {8'(8'h10 + i), 1'b1, 4'd4}) begin
                bad++; $display("FAIL simul_stream cyc=%0d got word=%h vld=%b cnt=%0d exp word=%h vld=1 cnt=4",
                                i, w, v, count, 8'h10 + i);
            end
        end
        total++;
        if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL simul_no_errors got ov=%b un=%b exp 0 0", overflow, underflow);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 8'h00, 1'b1, 1'b0, w, v);
            total++;
            if (w !== 8'(8'h24 + i)) begin
                bad++; $display("FAIL simul_drain idx=%0d got=%h exp=%h", i, w, 8'h24 + i);
            end
        end
        xfer(1'b1, 8'h55, 1'b1, 1'b0, w, v);
        total++;
        if ({underflow, overflow, count} !== {1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL simul_at_empty got un=%b ov=%b cnt=%0d exp un=1 ov=0 cnt=1", underflow, overflow, count);
        end
        xfer(1'b0, 8'h00, 1'b0, 1'b1, w, v);
        for (int i = 0; i < 7; i++) xfer(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, w, v);
        xfer(1'b1, 8'h99, 1'b1, 1'b0, w, v);
        total++;
        if ({w, v, overflow, underflow, count} !== {8'h55, 1'b1, 1'b1, 1'b0, 4'd7}) begin
            bad++; $display("FAIL simul_at_full got word=%h vld=%b ov=%b un=%b cnt=%0d exp word=55 vld=1 ov=1 un=0 cnt=7",
                            w, v, overflow, underflow, count);
        end
        for (int i = 0; i < 7; i++) begin
            xfer(1'b0, 8'h00, 1'b1, 1'b0, w, v);
            total++;
            if (w !== 8'(8'h60 + i)) begin
                bad++; $display("FAIL simul_full_drain idx=%0d got=%h exp=%h", i, w, 8'h60 + i);
            end
        end
        xfer(1'b0, 8'h00, 1'b0, 1'b1, w, v);
    endtask

    task automatic test_thresholds();
        logic [7:0] w;
        logic       v;
        for (int lap = 0; lap < 3; lap++) begin
            for (int k = 1; k <= 8; k++) begin
                xfer(1'b1, 8'(lap * 16 + k), 1'b0, 1'b0, w, v);
                total++;
                if ({almost_empty, almost_full, count} !== {1'(k <= 2), 1'(k >= 6), 4'(k)}) begin
                    bad++; $display("FAIL thr_fill lap=%0d cnt=%0d got ae=%b af=%b exp ae=%b af=%b",
                                    lap, count, almost_empty, almost_full, k <= 2, k >= 6);
                end
            end
            for (int k = 7; k >= 0; k--) begin
                xfer(1'b0, 8'h00, 1'b1, 1'b0, w, v);
                total++;
                if ({almost_empty, almost_full, w} !== {1'(k <= 2), 1'(k >= 6), 8'(lap * 16 + 8 - k)}) begin
                    bad++; $display("FAIL thr_drain lap=%0d cnt=%0d got ae=%b af=%b word=%h exp ae=%b af=%b word=%h",
                                    lap, count, almost_empty, almost_full, w, k <= 2, k >= 6, lap * 16 + 8 - k);
                end
            end
        end
        total++;
        if ({empty, overflow, underflow} !== 3'b100) begin
            bad++; $display("FAIL thr_wrap_clean got e=%b ov=%b un=%b exp 1 0 0", empty, overflow, underflow);
        end
    endtask

    task automatic test_read_timing();
        logic [7:0] w;
        logic       v;
        wr_en = 1'b1; data_in = 8'h3C;
        @(posedge clk); #1;
        wr_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
        total++;
        if ({data_out, rd_valid} !== {8'h3C, 1'b1}) begin
            bad++; $display("FAIL fwft_present got do=%h vld=%b exp do=3c vld=1", data_out, rd_valid);
        end
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        total++;
        if ({empty, rd_valid, data_out} !== {1'b1, 1'b0, 8'h3C}) begin
            bad++; $display("FAIL fwft_pop got e=%b vld=%b do=%h exp e=1 vld=0 do=3c", empty, rd_valid, data_out);
        end
`else
        total++;
        if (rd_valid !== 1'b0 || data_out === 8'h3C) begin
            bad++; $display("FAIL std_no_early_data got do=%h vld=%b exp vld=0 and stale data", data_out, rd_valid);
        end
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        total++;
        if ({data_out, rd_valid, empty} !== {8'h3C, 1'b1, 1'b1}) begin
            bad++; $display("FAIL std_latency got do=%h vld=%b e=%b exp do=3c vld=1 e=1", data_out, rd_valid, empty);
        end
        xfer(1'b0, 8'h00, 1'b0, 1'b0, w, v);
        total++;
        if ({data_out, rd_valid} !== {8'h3C, 1'b0}) begin
            bad++; $display("FAIL std_valid_pulse got do=%h vld=%b exp do=3c vld=0", data_out, rd_valid);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_thresholds();
        test_read_timing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
